// File: rtl/pe_pkg.sv
// Shared types for the PE column: drain channel and collector FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_pkg;

  // Width of one accumulated PE result.
  localparam int DATA_WIDTH = 16;

  // One PE row's drain channel: enable is high for one cycle with a valid result.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  enable;
  } drain_data_t;

  // Output sequencer state of the drain collector.
  typedef enum logic {
    WAIT = 1'b0,
    SEND = 1'b1
  } collector_state_e;

endpackage

// File: rtl/drain_hold_reg.sv
// Single-row holding register for one drained PE result.
// Latency: a write is visible on full/data the cycle after wr_en.
// Backpressure: a write into an occupied register that is not being cleared is
// dropped (old value kept) and flagged on ovf in the same cycle.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_en/wr_data: incoming drain result
//   clr          : current value is being moved to the output this cycle
//   full/data    : occupancy and stored value
//   ovf          : combinational, high when this cycle's write is being lost
module drain_hold_reg
  import pe_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ovf
);

  // A write is accepted when the slot is empty or is being emptied this cycle.
  logic wr_accept;

  always_comb begin
    wr_accept = wr_en && (!full || clr);
    ovf       = wr_en && full && !clr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_accept) begin
      // Simultaneous clear and write: the old value has already been taken by
      // the output register, so the slot refills and stays full.
      full <= 1'b1;
      data <= wr_data;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/drain_collector.sv
// Collects one systolic column's drained results and emits them in strict row order.
// Latency: enable on the pending row in WAIT -> out_valid_o two cycles later; back-to-back when pre-buffered.
// Backpressure: out_valid_o/out_data_o/out_row_o hold until out_ready_i; later rows wait in their holding regs.
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   drain_i[ROWS]         : per-row drain channel (data, enable)
//   out_valid_o/out_ready_i/out_data_o/out_row_o : result stream
//   tile_done_o           : one-cycle pulse after row ROWS-1 is accepted
//   overflow_o            : sticky, a drain result was lost
module drain_collector
  import pe_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  drain_data_t [ROWS-1:0]       drain_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [RW-1:0]                out_row_o,
  output logic                         tile_done_o,
  output logic                         overflow_o
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [ROWS-1:0]       hold_full;
  logic [ROWS-1:0]       hold_clr;
  logic [ROWS-1:0]       hold_ovf;
  logic [DATA_WIDTH-1:0] hold_data [ROWS];

  collector_state_e state;
  logic [RW-1:0]    ptr;
  logic [RW-1:0]    nxt;
  logic [RW-1:0]    load_idx;
  logic             hs;
  logic             load;

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    drain_hold_reg u_hold (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (drain_i[g].enable),
      .wr_data (drain_i[g].data),
      .clr     (hold_clr[g]),
      .full    (hold_full[g]),
      .data    (hold_data[g]),
      .ovf     (hold_ovf[g])
    );
  end

  // In WAIT the row being waited for is ptr itself; in SEND ptr is already
  // in the output register, so the candidate for a back-to-back load is ptr+1.
  always_comb begin
    nxt      = (ptr == LAST_ROW) ? '0 : ptr + RW'(1);
    hs       = (state == SEND) && out_ready_i;
    load_idx = (state == WAIT) ? ptr : nxt;
    load     = (state == WAIT) ? hold_full[ptr] : (hs && hold_full[nxt]);
    hold_clr = '0;
    if (load) hold_clr[load_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= WAIT;
      ptr         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_row_o   <= '0;
      tile_done_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      tile_done_o <= hs && (ptr == LAST_ROW);
      overflow_o  <= overflow_o | (|hold_ovf);
      if (hs) ptr <= nxt;

      case (state)
        WAIT: begin
          if (load) begin
            out_data_o  <= hold_data[load_idx];
            out_row_o   <= load_idx;
            out_valid_o <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (load) begin
              out_data_o  <= hold_data[load_idx];
              out_row_o   <= load_idx;
            end else begin
              out_valid_o <= 1'b0;
              state       <= WAIT;
            end
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          state       <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drain_collector.sv
module tb_drain_collector;
  import pe_pkg::*;

  localparam int ROWS = 4;
  localparam int RW   = $clog2(ROWS);

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  drain_data_t [ROWS-1:0] drain;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_WIDTH-1:0]  out_data_o;
  logic [RW-1:0]          out_row_o;
  logic                   tile_done_o;
  logic                   overflow_o;

  int checks = 0;
  int errors = 0;

  drain_collector #(.ROWS(ROWS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .drain_i     (drain),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_row_o   (out_row_o),
    .tile_done_o (tile_done_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [RW-1:0] r,
                         input logic [DATA_WIDTH-1:0] d);
    chk({tag, ".valid"}, 32'(out_valid_o), 32'(v));
    if (v) begin
      chk({tag, ".row"},  32'(out_row_o),  32'(r));
      chk({tag, ".data"}, 32'(out_data_o), 32'(d));
    end
  endtask

  task automatic drv(input int r, input logic [DATA_WIDTH-1:0] d);
    drain[r].enable = 1'b1;
    drain[r].data   = d;
  endtask

  task automatic idle();
    for (int i = 0; i < ROWS; i++) begin
      drain[i].enable = 1'b0;
      drain[i].data   = '0;
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    out_ready_i = 1'b0;
    idle();
    step();
    step();
    // ---- reset state
    chk("rst.valid", 32'(out_valid_o), 0);
    chk("rst.data",  32'(out_data_o),  0);
    chk("rst.row",   32'(out_row_o),   0);
    chk("rst.done",  32'(tile_done_o), 0);
    chk("rst.ovf",   32'(overflow_o),  0);
    rst_i = 1'b0;
    step();

    // ---- skewed drain, ready tied high
    out_ready_i = 1'b1;
    drv(0, 16'd5); step();
    idle(); drv(1, 16'd6);
    chk("skew.lat", 32'(out_valid_o), 0);
    step();
    chk_out("skew.r0", 1'b1, 2'd0, 16'd5);
    idle(); drv(2, 16'd7); step();
    chk_out("skew.r1", 1'b1, 2'd1, 16'd6);
    idle(); drv(3, 16'd8); step();
    chk_out("skew.r2", 1'b1, 2'd2, 16'd7);
    chk("skew.nodone", 32'(tile_done_o), 0);
    idle(); step();
    chk_out("skew.r3", 1'b1, 2'd3, 16'd8);
    step();
    chk("skew.done", 32'(tile_done_o), 1);
    chk_out("skew.end", 1'b0, 2'd0, 16'd0);
    step();
    chk("skew.done_pulse", 32'(tile_done_o), 0);
    chk("skew.ovf", 32'(overflow_o), 0);

    // ---- out-of-order arrival
    drv(2, 16'd30); step();
    idle(); drv(0, 16'd10); step();
    chk_out("ooo.hold", 1'b0, 2'd0, 16'd0);
    idle(); drv(3, 16'd40); step();
    chk_out("ooo.r0", 1'b1, 2'd0, 16'd10);
    idle(); drv(1, 16'd20); step();
    chk_out("ooo.gap", 1'b0, 2'd0, 16'd0);
    idle(); step();
    chk_out("ooo.r1", 1'b1, 2'd1, 16'd20);
    step();
    chk_out("ooo.r2", 1'b1, 2'd2, 16'd30);
    step();
    chk_out("ooo.r3", 1'b1, 2'd3, 16'd40);
    step();
    chk("ooo.done", 32'(tile_done_o), 1);

    // ---- backpressure
    out_ready_i = 1'b0;
    drv(0, 16'hAA); drv(1, 16'hBB); step();
    idle(); step();
    for (int i = 0; i < 6; i++) begin
      chk_out("bp.stall", 1'b1, 2'd0, 16'hAA);
      step();
    end
    chk_out("bp.stall_end", 1'b1, 2'd0, 16'hAA);
    out_ready_i = 1'b1;
    step();
    chk_out("bp.r1", 1'b1, 2'd1, 16'hBB);
    drv(2, 16'hC2); drv(3, 16'hC3); step();
    idle();
    chk_out("bp.gap", 1'b0, 2'd0, 16'd0);
    step();
    chk_out("bp.r2", 1'b1, 2'd2, 16'hC2);
    step();
    chk_out("bp.r3", 1'b1, 2'd3, 16'hC3);
    step();
    chk("bp.done", 32'(tile_done_o), 1);
    chk("bp.ovf", 32'(overflow_o), 0);

    // ---- overflow on row 1 while stalled on row 0
    out_ready_i = 1'b0;
    drv(0, 16'h01); step();
    idle(); drv(1, 16'h11); step();
    idle(); drv(1, 16'h22); step();
    idle();
    chk("ovf.set", 32'(overflow_o), 1);
    chk_out("ovf.r0", 1'b1, 2'd0, 16'h01);
    step(); step();
    chk("ovf.sticky", 32'(overflow_o), 1);
    out_ready_i = 1'b1;
    step();
    chk_out("ovf.r1_old", 1'b1, 2'd1, 16'h11);
    drv(2, 16'h33); drv(3, 16'h44); step();
    idle(); step();
    chk_out("ovf.r2", 1'b1, 2'd2, 16'h33);
    step();
    chk_out("ovf.r3", 1'b1, 2'd3, 16'h44);
    step();
    chk("ovf.done", 32'(tile_done_o), 1);
    chk("ovf.sticky2", 32'(overflow_o), 1);
    rst_i = 1'b1; step();
    rst_i = 1'b0;
    chk("ovf.cleared", 32'(overflow_o), 0);

    // ---- simultaneous load and write on row 0
    out_ready_i = 1'b0;
    drv(0, 16'h50); step();
    idle(); drv(0, 16'h99); step();
    idle();
    chk_out("sim.old", 1'b1, 2'd0, 16'h50);
    chk("sim.ovf", 32'(overflow_o), 0);
    out_ready_i = 1'b1;
    drv(1, 16'h61); drv(2, 16'h62); drv(3, 16'h63); step();
    idle();
    chk_out("sim.gap", 1'b0, 2'd0, 16'd0);
    step();
    chk_out("sim.r1", 1'b1, 2'd1, 16'h61);
    step();
    chk_out("sim.r2", 1'b1, 2'd2, 16'h62);
    step();
    chk_out("sim.r3", 1'b1, 2'd3, 16'h63);
    step();
    chk("sim.done", 32'(tile_done_o), 1);
    chk_out("sim.new", 1'b1, 2'd0, 16'h99);
    chk("sim.ovf2", 32'(overflow_o), 0);

    // ---- reset mid-tile after rows 0 and 1
    out_ready_i = 1'b0;
    drv(1, 16'h71); step();
    idle();
    chk_out("rmt.r0", 1'b1, 2'd0, 16'h99);
    out_ready_i = 1'b1;
    step();
    chk_out("rmt.r1", 1'b1, 2'd1, 16'h71);
    step();
    chk_out("rmt.wait2", 1'b0, 2'd0, 16'd0);
    drv(2, 16'h72); step();
    idle();
    rst_i = 1'b1; step();
    chk("rmt.valid", 32'(out_valid_o), 0);
    chk("rmt.data",  32'(out_data_o),  0);
    chk("rmt.row",   32'(out_row_o),   0);
    chk("rmt.done",  32'(tile_done_o), 0);
    rst_i = 1'b0;
    step();
    chk("rmt.done2", 32'(tile_done_o), 0);
    drv(2, 16'h0C); step();
    idle(); step(); step();
    chk_out("rmt.no_r2", 1'b0, 2'd0, 16'd0);
    drv(0, 16'h0A); step();
    idle(); step();
    chk_out("rmt.restart", 1'b1, 2'd0, 16'h0A);
    step();
    chk_out("rmt.next", 1'b0, 2'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
